seq_fsm_stop_light_timer: RTL and testbench

- Drives the `change` input of the stop-light FSM (green_on/yellow_on/red_on outputs, starting_yellow/change inputs).
- Observes the three light outputs and counts how many cycles the current light has been on.
- Asserts `change` when the dwell time for that light has elapsed.
- Optionally shortens green on a pedestrian request and drives a walk signal.

---
 rtl/stop_light_pkg.sv | 31 +++
 rtl/stop_light_dwell_counter.sv | 38 +++
 rtl/seq_fsm_stop_light_timer.sv | 113 +++++++++++
 tb/tb_seq_fsm_stop_light_timer.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/stop_light_pkg.sv
// Shared stop-light types: light phase encoding and the one-hot light decoder.
package stop_light_pkg;

    typedef enum logic [1:0] {
        PhaseNone = 2'd0,
        PhaseG    = 2'd1,
        PhaseY    = 2'd2,
        PhaseR    = 2'd3
    } phase_e;

    typedef struct packed {
        phase_e phase;
        logic   error;
    } decode_t;

    // Exactly one light on gives a phase; anything else is illegal.
    function automatic decode_t decode_lights(input logic green, input logic yellow,
                                              input logic red);
        decode_t dec;
        dec.phase = PhaseNone;
        dec.error = 1'b1;
        case ({green, yellow, red})
            3'b100: begin dec.phase = PhaseG; dec.error = 1'b0; end
            3'b010: begin dec.phase = PhaseY; dec.error = 1'b0; end
            3'b001: begin dec.phase = PhaseR; dec.error = 1'b0; end
            default: ;
        endcase
        return dec;
    endfunction

endpackage

// File: rtl/stop_light_dwell_counter.sv
// Saturating dwell counter with clear / load-one / increment controls (clear wins).
module stop_light_dwell_counter #(
    parameter int unsigned CNT_NBITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 load_one,
    input  logic                 inc,
    output logic [CNT_NBITS-1:0] cnt
);

    localparam logic [CNT_NBITS-1:0] CntMax = '1;

    logic [CNT_NBITS-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (load_one) begin
            cnt_d = CNT_NBITS'(1);
        end else if (inc && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + CNT_NBITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/seq_fsm_stop_light_timer.sv
// Dwell timer that drives `change` of the stop-light FSM from the observed lights.
// Define STOP_LIGHT_TIMER_PED_EN to enable the pedestrian request / walk feature.
module seq_fsm_stop_light_timer
    import stop_light_pkg::*;
#(
    parameter int unsigned GREEN_CYCLES     = 4,
    parameter int unsigned YELLOW_CYCLES    = 2,
    parameter int unsigned RED_CYCLES       = 3,
    parameter int unsigned MIN_GREEN_CYCLES = 2,
    parameter int unsigned CNT_NBITS        = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic green_on,
    input  logic yellow_on,
    input  logic red_on,
    input  logic ped_req,
    output logic change,
    output logic walk_on,
    output logic error
);

    localparam logic [CNT_NBITS-1:0] GreenLast    = CNT_NBITS'(GREEN_CYCLES - 1);
    localparam logic [CNT_NBITS-1:0] YellowLast   = CNT_NBITS'(YELLOW_CYCLES - 1);
    localparam logic [CNT_NBITS-1:0] RedLast      = CNT_NBITS'(RED_CYCLES - 1);
    localparam logic [CNT_NBITS-1:0] MinGreenLast = CNT_NBITS'(MIN_GREEN_CYCLES - 1);

    decode_t              dec;
    phase_e               phase, phase_d, phase_q;
    logic [CNT_NBITS-1:0] cnt, elapsed, last;
    logic                 timeout, ped_early;
    logic                 cnt_clear, cnt_load, cnt_inc;

    assign dec   = decode_lights(green_on, yellow_on, red_on);
    assign phase = dec.phase;

    always_comb begin
        elapsed = (phase == phase_q) ? cnt : '0;
        case (phase)
            PhaseG:  last = GreenLast;
            PhaseY:  last = YellowLast;
            PhaseR:  last = RedLast;
            default: last = '0;
        endcase
        timeout   = (phase != PhaseNone) && (elapsed >= last);
        change    = (timeout || ped_early) && !reset;
        error     = dec.error && !reset;
        cnt_clear = (phase == PhaseNone);
        cnt_inc   = (phase == phase_q);
        cnt_load  = !cnt_clear && !cnt_inc;
        phase_d   = phase;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= PhaseNone;
        end else begin
            phase_q <= phase_d;
        end
    end

    stop_light_dwell_counter #(
        .CNT_NBITS (CNT_NBITS)
    ) u_dwell_counter (
        .clk      (clk),
        .reset    (reset),
        .clear    (cnt_clear),
        .load_one (cnt_load),
        .inc      (cnt_inc),
        .cnt      (cnt)
    );

`ifdef STOP_LIGHT_TIMER_PED_EN
    logic ped_pending_d, ped_pending_q;
    logic ped_served_d, ped_served_q;

    assign ped_early = (phase == PhaseG) && ped_pending_q && (elapsed >= MinGreenLast);
    assign walk_on   = (phase == PhaseR) && ped_served_q && !reset;

    // A request is consumed when green ends; a fresh press (even the same cycle) re-arms it.
    always_comb begin
        ped_pending_d = ped_pending_q;
        ped_served_d  = ped_served_q;
        if ((phase == PhaseG) && change && ped_pending_q) begin
            ped_served_d  = 1'b1;
            ped_pending_d = 1'b0;
        end
        if ((phase_q == PhaseR) && (phase != PhaseR)) begin
            ped_served_d = 1'b0;
        end
        if (ped_req) begin
            ped_pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ped_pending_q <= 1'b0;
            ped_served_q  <= 1'b0;
        end else begin
            ped_pending_q <= ped_pending_d;
            ped_served_q  <= ped_served_d;
        end
    end
`else
    logic unused_ped;

    assign ped_early  = 1'b0;
    assign walk_on    = 1'b0;
    assign unused_ped = ped_req ^ MinGreenLast[0];
`endif

endmodule

// File: tb/tb_seq_fsm_stop_light_timer.sv
// Directed self-checking bench for seq_fsm_stop_light_timer (default parameters).
module tb_seq_fsm_stop_light_timer;

    localparam logic [2:0] LG = 3'b100;
    localparam logic [2:0] LY = 3'b010;
    localparam logic [2:0] LR = 3'b001;
`ifdef STOP_LIGHT_TIMER_PED_EN
    localparam int   GreenPed = 2;
    localparam logic PedEn    = 1'b1;
`else
    localparam int   GreenPed = 4;
    localparam logic PedEn    = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset, green_on, yellow_on, red_on, ped_req;
    logic change, walk_on, error;

    int checks   = 0;
    int failures = 0;

    seq_fsm_stop_light_timer dut (
        .clk       (clk),
        .reset     (reset),
        .green_on  (green_on),
        .yellow_on (yellow_on),
        .red_on    (red_on),
        .ped_req   (ped_req),
        .change    (change),
        .walk_on   (walk_on),
        .error     (error)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check outputs at the falling edge, advance.
    task automatic cyc(input logic [2:0] lights, input logic p, input logic exp_chg,
                       input logic exp_walk, input string tag);
        logic exp_err;
        {green_on, yellow_on, red_on} = lights;
        ped_req = p;
        exp_err = ($countones(lights) != 1) && !reset;
        @(negedge clk);
        check_eq({tag, "_change"}, change, exp_chg);
        check_eq({tag, "_walk"}, walk_on, exp_walk);
        check_eq({tag, "_error"}, error, exp_err);
        @(posedge clk);
        #1;
    endtask

    // Reset cycle with illegal lights to confirm error/change/walk are gated.
    task automatic do_reset(input logic p);
        reset = 1'b1;
        cyc(3'b101, p, 1'b0, 1'b0, "reset");
        reset = 1'b0;
    endtask

    initial begin
        logic [2:0] seg_l[7];
        int         seg_n[7];
        logic [2:0] exp_l[20];
        logic       exp_c[20];
        logic [2:0] st_lights[4];
        int         st, k, bad;
        logic       chg;

        reset = 1'b1;
        {green_on, yellow_on, red_on, ped_req} = 4'b0;
        @(posedge clk);
        #1;

        // Open loop: G x4, Y x2, R x3.
        do_reset(1'b0);
        for (int i = 0; i < 4; i++) cyc(LG, 1'b0, i == 3, 1'b0, "open_g");
        for (int i = 0; i < 2; i++) cyc(LY, 1'b0, i == 1, 1'b0, "open_y");
        for (int i = 0; i < 3; i++) cyc(LR, 1'b0, i == 2, 1'b0, "open_r");

        // Closed loop with a Moore light FSM in starting_yellow mode.
        seg_l = '{LG, LY, LR, LY, LG, LY, LR};
        seg_n = '{4, 2, 3, 2, 4, 2, 3};
        k = 0;
        for (int s = 0; s < 7; s++) begin
            for (int j = 0; j < seg_n[s]; j++) begin
                exp_l[k] = seg_l[s];
                exp_c[k] = (j == seg_n[s] - 1);
                k++;
            end
        end
        st_lights = '{LG, LY, LR, LY};
        do_reset(1'b0);
        st = 0;
        for (int i = 0; i < 20; i++) begin
            {green_on, yellow_on, red_on} = st_lights[st];
            ped_req = 1'b0;
            @(negedge clk);
            chg = change;
            check_eq("loop_lights", st_lights[st], exp_l[i]);
            check_eq("loop_change", chg, exp_c[i]);
            if (chg) st = (st + 1) % 4;
            @(posedge clk);
            #1;
        end

        // Illegal encodings mid-green restart the count.
        do_reset(1'b0);
        cyc(LG, 1'b0, 1'b0, 1'b0, "ill_g_pre");
        cyc(LG, 1'b0, 1'b0, 1'b0, "ill_g_pre");
        cyc(3'b101, 1'b0, 1'b0, 1'b0, "ill_gr");
        for (int i = 0; i < 4; i++) cyc(LG, 1'b0, i == 3, 1'b0, "ill_g_post");
        cyc(3'b000, 1'b0, 1'b0, 1'b0, "ill_none");
        for (int i = 0; i < 4; i++) cyc(LG, 1'b0, i == 3, 1'b0, "ill_g_post2");

        // Reset mid-green: full green dwell afterwards.
        do_reset(1'b0);
        cyc(LG, 1'b0, 1'b0, 1'b0, "rst_g_pre");
        cyc(LG, 1'b0, 1'b0, 1'b0, "rst_g_pre");
        reset = 1'b1;
        cyc(LG, 1'b0, 1'b0, 1'b0, "rst_mid");
        reset = 1'b0;
        for (int i = 0; i < 4; i++) cyc(LG, 1'b0, i == 3, 1'b0, "rst_g_post");

        // ped_req during reset is dropped.
        do_reset(1'b1);
        for (int i = 0; i < 4; i++) cyc(LG, 1'b0, i == 3, 1'b0, "ped_rst_g");

        // Pedestrian service: shortened green, walk during red, request latched in red.
        do_reset(1'b0);
        for (int i = 0; i < GreenPed; i++) cyc(LG, i == 0, i == GreenPed - 1, 1'b0, "ped_g1");
        for (int i = 0; i < 2; i++) cyc(LY, 1'b0, i == 1, 1'b0, "ped_y1");
        for (int i = 0; i < 3; i++) cyc(LR, i == 1, i == 2, PedEn, "ped_r");
        for (int i = 0; i < 2; i++) cyc(LY, 1'b0, i == 1, 1'b0, "ped_y2");
        for (int i = 0; i < GreenPed; i++) cyc(LG, 1'b0, i == GreenPed - 1, 1'b0, "ped_g2");
        for (int i = 0; i < 2; i++) cyc(LY, 1'b0, i == 1, 1'b0, "ped_y3");
        cyc(LR, 1'b0, 1'b0, PedEn, "ped_r2");

        // Long green: counter saturates, change stays high past 2^CNT_NBITS cycles.
        do_reset(1'b0);
        {green_on, yellow_on, red_on} = LG;
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (change !== (i >= 3)) bad++;
            @(posedge clk);
            #1;
        end
        check_eq("sat_bad_cycles", bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
